// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, IR field positions, sequencer states and opcode classes
package ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_INC = 5'b11111;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_e;

    typedef enum logic [2:0] {
        C_ALU, C_MULDIV, C_UNARY, C_MFHI, C_MFLO, C_NOP, C_HALT, C_BAD
    } class_e;

    function automatic class_e classify(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return C_ALU;
            OP_MUL, OP_DIV:                  return C_MULDIV;
            OP_NEG, OP_NOT:                  return C_UNARY;
            OP_MFHI:                         return C_MFHI;
            OP_MFLO:                         return C_MFLO;
            OP_NOP:                          return C_NOP;
            OP_HALT:                         return C_HALT;
            default:                         return C_BAD;
        endcase
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// rtl/reg_field_decoder.sv - 4-bit register field to one-hot R0..R15 strobe
module reg_field_decoder (
    input  logic [3:0]  field_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);

    assign onehot_o = en_i ? (16'd1 << field_i) : 16'd0;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute sequencer; CTRL_PERF_CNT_EN adds perf counters
import ctrl_pkg::*;

module control_sequencer #(
    parameter int WAIT_LIMIT = 255,
    parameter int IR_W       = 32
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_ready,
    output logic [15:0]     gpr_out,
    output logic [15:0]     gpr_in,
    output logic            PCout,
    output logic            RZHIout,
    output logic            RZLOout,
    output logic            HIout,
    output logic            LOout,
    output logic            MDRout,
    output logic            MARin,
    output logic            PCin,
    output logic            IRin,
    output logic            RYin,
    output logic            RZin,
    output logic            HIin,
    output logic            LOin,
    output logic            MDRin,
    output logic            Read,
    output logic [4:0]      ops,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic            bus_err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]     instr_count,
    output logic [31:0]     cycle_count
`endif
);

    localparam int WW = $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;
    logic          gout_en, gin_en, last_step;
    logic [3:0]    gout_sel, gin_sel;
    logic [3:0]    ra, rb, rc;
    logic [4:0]    opc;
    class_e        cls;
    logic          unused_ir_bits;

    assign opc = ir[OPC_HI:OPC_LO];
    assign ra  = ir[RA_HI:RA_LO];
    assign rb  = ir[RB_HI:RB_LO];
    assign rc  = ir[RC_HI:RC_LO];
    assign cls = classify(opc);
    assign unused_ir_bits = ^ir[RC_LO-1:0];

    // State register, fetch wait counter and sticky fault flags
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state plus Moore strobe decode from state and the latched IR
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        gout_en   = 1'b0;
        gout_sel  = rb;
        gin_en    = 1'b0;
        gin_sel   = ra;
        last_step = 1'b0;
        PCout = 1'b0; RZHIout = 1'b0; RZLOout = 1'b0; HIout = 1'b0; LOout = 1'b0; MDRout = 1'b0;
        MARin = 1'b0; PCin = 1'b0; IRin = 1'b0; RYin = 1'b0; RZin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; MDRin = 1'b0; Read = 1'b0;
        ops    = 5'd0;
        halted = 1'b0;
        case (state_q)
            IDLE: if (run) state_d = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; ops = ALU_INC; RZin = 1'b1;
                state_d = T1;
            end
            T1: begin
                RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_ready) begin
                    state_d = T2;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = HALT;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = T3;
            end
            T3: begin
                state_d = T4;
                case (cls)
                    C_ALU:    begin gout_en = 1'b1; RYin = 1'b1; end
                    C_MULDIV: begin gout_en = 1'b1; gout_sel = ra; RYin = 1'b1; end
                    C_UNARY:  begin gout_en = 1'b1; ops = opc; RZin = 1'b1; end
                    C_MFHI:   begin HIout = 1'b1; gin_en = 1'b1; last_step = 1'b1; end
                    C_MFLO:   begin LOout = 1'b1; gin_en = 1'b1; last_step = 1'b1; end
                    C_NOP:    last_step = 1'b1;
                    C_HALT:   state_d = HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end
                endcase
            end
            T4: begin
                state_d = T5;
                case (cls)
                    C_ALU:    begin gout_en = 1'b1; gout_sel = rc; ops = opc; RZin = 1'b1; end
                    C_MULDIV: begin gout_en = 1'b1; ops = opc; RZin = 1'b1; end
                    C_UNARY:  begin RZLOout = 1'b1; gin_en = 1'b1; last_step = 1'b1; end
                    default:  state_d = IDLE;
                endcase
            end
            T5: begin
                state_d = T6;
                case (cls)
                    C_ALU:    begin RZLOout = 1'b1; gin_en = 1'b1; last_step = 1'b1; end
                    C_MULDIV: begin RZLOout = 1'b1; LOin = 1'b1; end
                    default:  state_d = IDLE;
                endcase
            end
            T6: begin
                RZHIout = 1'b1; HIin = 1'b1; last_step = 1'b1;
            end
            HALT: halted = 1'b1;
            default: state_d = IDLE;
        endcase
        if (last_step) state_d = run ? T0 : IDLE;
    end

    assign busy    = (state_q != IDLE) && (state_q != HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

    reg_field_decoder u_gpr_out (.field_i(gout_sel), .en_i(gout_en), .onehot_o(gpr_out));
    reg_field_decoder u_gpr_in  (.field_i(gin_sel),  .en_i(gin_en),  .onehot_o(gpr_in));

`ifdef CTRL_PERF_CNT_EN
    logic        instr_done;
    logic [31:0] instr_q, cycle_q;

    assign instr_done = last_step || ((state_q == T3) && ((cls == C_HALT) || (cls == C_BAD)));

    // Retired-instruction and busy-cycle counters, free-running wrap
    always_ff @(posedge clock) begin
        if (clear) begin
            instr_q <= 32'd0;
            cycle_q <= 32'd0;
        end else begin
            if (instr_done) instr_q <= instr_q + 32'd1;
            if (busy)       cycle_q <= cycle_q + 32'd1;
        end
    end

    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench with random instruction stream and reference step model
module tb_control_sequencer;

    localparam int WL = 12;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] ir;
    logic [15:0] gpr_out, gpr_in;
    logic PCout, RZHIout, RZLOout, HIout, LOout, MDRout;
    logic MARin, PCin, IRin, RYin, RZin, HIin, LOin, MDRin, Read;
    logic [4:0] ops;
    logic busy, halted, illegal, bus_err;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count, cycle_count;
`endif

    control_sequencer #(.WAIT_LIMIT(WL), .IR_W(32)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .gpr_out(gpr_out), .gpr_in(gpr_in),
        .PCout(PCout), .RZHIout(RZHIout), .RZLOout(RZLOout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .HIin(HIin), .LOin(LOin),
        .MDRin(MDRin), .Read(Read), .ops(ops), .busy(busy), .halted(halted),
        .illegal(illegal), .bus_err(bus_err)
`ifdef CTRL_PERF_CNT_EN
        , .instr_count(instr_count), .cycle_count(cycle_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] go;
        logic [15:0] gi;
        logic pco, rzhio, rzloo, hio, loo, mdro;
        logic marin, pcin, irin, ryin, rzin, hiin, loin, mdrin, rd;
        logic [4:0] ops;
        logic busy, halted, ill, berr;
    } vec_t;

    vec_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    vec_t plan_v[$];
    int   plan_r[$];
    int   end_kind;

    bit   mdl_idle, mdl_ill, mdl_berr;
    int   mdl_instr, mdl_busy;

    logic [4:0] legal_ops [16] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                   5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001,
                                   5'b10010, 5'b10111, 5'b11000, 5'b11001};

    function automatic vec_t dut_vec();
        vec_t v;
        v.go = gpr_out; v.gi = gpr_in;
        v.pco = PCout; v.rzhio = RZHIout; v.rzloo = RZLOout; v.hio = HIout; v.loo = LOout; v.mdro = MDRout;
        v.marin = MARin; v.pcin = PCin; v.irin = IRin; v.ryin = RYin; v.rzin = RZin;
        v.hiin = HIin; v.loin = LOin; v.mdrin = MDRin; v.rd = Read;
        v.ops = ops; v.busy = busy; v.halted = halted; v.ill = illegal; v.berr = bus_err;
        return v;
    endfunction

    // Compare every cycle the stimulus side has queued an expectation for
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            vec_t a;
            e = exp_q.pop_front();
            a = dut_vec();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL step%0d: got %h want %h", total, a, e);
            end
        end
    end

    function automatic vec_t blank(input bit b);
        vec_t v;
        v = '0;
        v.busy = b;
        return v;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] n);
        return 16'd1 << n;
    endfunction

    function automatic vec_t halt_vec();
        vec_t v;
        v = '0;
        v.halted = 1'b1;
        v.ill = mdl_ill;
        v.berr = mdl_berr;
        return v;
    endfunction

    function automatic void add_step(input vec_t v, input int r);
        plan_v.push_back(v);
        plan_r.push_back(r);
    endfunction

    // Reference: the strobe pattern of one instruction, cycle by cycle
    task automatic plan_instr(input logic [4:0] op, input logic [3:0] ra, rb, rc, input int waits);
        vec_t v;
        plan_v.delete();
        plan_r.delete();
        end_kind = 0;
        v = blank(1); v.pco = 1; v.marin = 1; v.ops = 5'b11111; v.rzin = 1;
        add_step(v, 0);
        v = blank(1); v.rzloo = 1; v.pcin = 1; v.rd = 1; v.mdrin = 1;
        if (waits >= WL) begin
            for (int i = 0; i < WL; i++) add_step(v, 2);
            end_kind = 3;
            return;
        end
        for (int i = 0; i < waits; i++) add_step(v, 2);
        add_step(v, 1);
        v = blank(1); v.mdro = 1; v.irin = 1;
        add_step(v, 0);
        if (op >= 5'b00011 && op <= 5'b01011) begin
            v = blank(1); v.go = oh(rb); v.ryin = 1; add_step(v, 0);
            v = blank(1); v.go = oh(rc); v.ops = op; v.rzin = 1; add_step(v, 0);
            v = blank(1); v.rzloo = 1; v.gi = oh(ra); add_step(v, 0);
        end else if (op == 5'b01111 || op == 5'b10000) begin
            v = blank(1); v.go = oh(ra); v.ryin = 1; add_step(v, 0);
            v = blank(1); v.go = oh(rb); v.ops = op; v.rzin = 1; add_step(v, 0);
            v = blank(1); v.rzloo = 1; v.loin = 1; add_step(v, 0);
            v = blank(1); v.rzhio = 1; v.hiin = 1; add_step(v, 0);
        end else if (op == 5'b10001 || op == 5'b10010) begin
            v = blank(1); v.go = oh(rb); v.ops = op; v.rzin = 1; add_step(v, 0);
            v = blank(1); v.rzloo = 1; v.gi = oh(ra); add_step(v, 0);
        end else if (op == 5'b10111) begin
            v = blank(1); v.hio = 1; v.gi = oh(ra); add_step(v, 0);
        end else if (op == 5'b11000) begin
            v = blank(1); v.loo = 1; v.gi = oh(ra); add_step(v, 0);
        end else if (op == 5'b11001) begin
            add_step(blank(1), 0);
        end else if (op == 5'b11010) begin
            add_step(blank(1), 0);
            end_kind = 1;
        end else begin
            add_step(blank(1), 0);
            end_kind = 2;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exec_instr(input logic [4:0] op, input logic [3:0] ra, rb, rc,
                              input int waits, input bit run_after, input int abort_at);
        int n;
        plan_instr(op, ra, rb, rc, waits);
        ir = {op, ra, rb, rc, 15'($urandom)};
        n = plan_v.size();
        if (mdl_idle) begin
            run = 1'b1; clear = 1'b0; mem_ready = 1'($urandom);
            exp_q.push_back(blank(0));
            tick();
            mdl_idle = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            case (plan_r[i])
                1: mem_ready = 1'b1;
                2: mem_ready = 1'b0;
                default: mem_ready = 1'($urandom);
            endcase
            run = (i == n - 1) ? run_after : 1'($urandom);
            clear = (i == abort_at);
            exp_q.push_back(plan_v[i]);
            mdl_busy++;
            tick();
            if (clear) begin
                clear = 1'b0; run = 1'b0;
                mdl_idle = 1'b1; mdl_busy = 0; mdl_instr = 0;
                return;
            end
        end
        case (end_kind)
            0: begin mdl_instr++; mdl_idle = !run_after; end
            1: mdl_instr++;
            2: begin mdl_instr++; mdl_ill = 1'b1; end
            default: mdl_berr = 1'b1;
        endcase
    endtask

    task automatic halted_then_clear(input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'($urandom); mem_ready = 1'($urandom);
            exp_q.push_back(halt_vec());
            tick();
        end
        clear = 1'b1;
        exp_q.push_back(halt_vec());
        tick();
        clear = 1'b0; run = 1'b0;
        mdl_ill = 1'b0; mdl_berr = 1'b0; mdl_idle = 1'b1; mdl_instr = 0; mdl_busy = 0;
        exp_q.push_back(blank(0));
        tick();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick();
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
        mdl_idle = 1'b1; mdl_ill = 1'b0; mdl_berr = 1'b0; mdl_instr = 0; mdl_busy = 0;
        tick(); tick();
        clear = 1'b0;
        exp_q.push_back(blank(0)); tick();
        exp_q.push_back(blank(0)); tick();

        exec_instr(5'b00011, 4'd3, 4'd1, 4'd2, 0, 1'b1, -1);
        exec_instr(5'b01111, 4'd4, 4'd5, 4'd0, 0, 1'b1, -1);
        exec_instr(5'b00011, 4'd7, 4'd8, 4'd9, 3, 1'b1, -1);
        exec_instr(5'b10010, 4'd2, 4'd6, 4'd0, 0, 1'b0, -1);
        exec_instr(5'b00011, 4'd3, 4'd1, 4'd2, 0, 1'b1, 4);
        exec_instr(5'b00011, 4'd15, 4'd0, 4'd15, 0, 1'b1, -1);

        for (int k = 0; k < 40; k++) begin
            exec_instr(legal_ops[$urandom_range(0, 15)], 4'($urandom), 4'($urandom), 4'($urandom),
                       $urandom_range(0, 3), 1'($urandom), -1);
        end
        exec_instr(5'b11001, 4'd0, 4'd0, 4'd0, 0, 1'b0, -1);
        drain();
`ifdef CTRL_PERF_CNT_EN
        total++;
        if (instr_count !== 32'(mdl_instr)) begin
            bad++;
            $display("FAIL instr_count: got %0d want %0d", instr_count, mdl_instr);
        end
        total++;
        if (cycle_count !== 32'(mdl_busy)) begin
            bad++;
            $display("FAIL cycle_count: got %0d want %0d", cycle_count, mdl_busy);
        end
`endif

        exec_instr(5'b11010, 4'd0, 4'd0, 4'd0, 1, 1'b1, -1);
        halted_then_clear(6);
        exec_instr(5'b01100, 4'd1, 4'd2, 4'd3, 0, 1'b1, -1);
        halted_then_clear(3);
        exec_instr(5'b00011, 4'd1, 4'd2, 4'd3, WL, 1'b1, -1);
        halted_then_clear(3);
        exec_instr(5'b10111, 4'd9, 4'd0, 4'd0, 2, 1'b0, -1);
        exec_instr(5'b11000, 4'd10, 4'd0, 4'd0, 0, 1'b0, -1);
        exp_q.push_back(blank(0));
        run = 1'b0;
        tick();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that sequences the bus-based CPU datapath through fetch and execute steps. It drives the datapath's register out/in strobes, Read, and the 5-bit ALU op, and handshakes with memory on instruction fetch. It sits beside the datapath, reads the latched IR, and handles a register-register ALU subset, mul/div, neg/not, mfhi/mflo, nop and halt.

Parameters:
WAIT_LIMIT, 255, maximum T1 cycles without mem_ready before bus error
IR_W, 32, instruction width

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
run  in  1  level; allows the sequencer to start or continue fetching
ir  in  32  current IR contents (opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15])
mem_ready  in  1  memory read data valid on Mdatain
gpr_out  out  16  one-hot R0..R15 out strobes
gpr_in  out  16  one-hot R0..R15 in strobes
PCout, RZHIout, RZLOout, HIout, LOout, MDRout  out  1 each  bus drive strobes
MARin, PCin, IRin, RYin, RZin, HIin, LOin, MDRin, Read  out  1 each  load strobes
ops  out  5  ALU operation
busy  out  1  high in any state other than IDLE or HALT
halted  out  1  high in HALT
illegal  out  1  sticky; unsupported opcode seen
bus_err  out  1  sticky; fetch wait exceeded WAIT_LIMIT

Behaviour:
- Moore FSM. Strobes decode combinationally from state and ir and are valid for the whole state cycle; the datapath captures at the next rising edge.
- On clear: state=IDLE; wait counter=0; illegal=bus_err=0. All strobes, ops, busy and halted are 0. Reset wins over every other event, including mid-instruction.
- IDLE: all strobes 0. run=1 -> T0.
- T0: PCout, MARin, ops=ALU_INC, RZin. -> T1.
- T1: RZLOout, PCin, Read, MDRin.
  - Stays in T1 while mem_ready=0, incrementing the wait counter. Repeated PCin reloads the same value.
  - mem_ready=1 -> T2 and counter cleared.
  - Counter reaching WAIT_LIMIT with mem_ready=0 -> set bus_err, go to HALT.
- T2: MDRout, IRin. -> T3.
- Execute states by class (ops=opcode unless stated):
  - ALU R-type (add, sub, and, or, shr, shra, shl, ror, rol):
    - T3: gpr_out[Rb], RYin.
    - T4: gpr_out[Rc], ops, RZin.
    - T5: RZLOout, gpr_in[Ra].
  - mul/div:
    - T3: gpr_out[Ra], RYin.
    - T4: gpr_out[Rb], ops, RZin.
    - T5: RZLOout, LOin.
    - T6: RZHIout, HIin.
  - neg/not:
    - T3: gpr_out[Rb], ops, RZin.
    - T4: RZLOout, gpr_in[Ra].
  - mfhi: T3: HIout, gpr_in[Ra]. mflo: T3: LOout, gpr_in[Ra].
  - nop: T3 with no strobes.
  - halt: T3 -> HALT.
  - Any other opcode: set illegal, -> HALT.
- Last execute state -> T0 if run=1, else IDLE. run falling mid-instruction takes effect only at instruction end.
- Instruction lengths (no fetch wait): R-type 6 cycles, mul/div 7, neg/not 5, mfhi/mflo/nop 4.
- HALT: all strobes 0, halted=1. Exits only on clear.
- At most one bus-drive strobe is high in any cycle. gpr_in and gpr_out are each one-hot or zero.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: adds outputs instr_count[31:0] and cycle_count[31:0].
  - instr_count increments on each transition out of an execute state's last cycle, including halt.
  - cycle_count increments whenever busy=1.
  - Both reset to 0 on clear and wrap at 2^32.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants: ADD=00011, SUB=00100, AND=00101, OR=00110, SHR=00111, SHRA=01000, SHL=01001, ROR=01010, ROL=01011, MUL=01111, DIV=10000, NEG=10001, NOT=10010, MFHI=10111, MFLO=11000, NOP=11001, HALT=11010
  - ALU_INC=11111
  - IR field bit positions
  - state enum (IDLE, T0..T6, HALT)
- One sub-module: reg_field_decoder (4-bit field + enable -> 16-bit one-hot), instantiated for gpr_out and gpr_in.

Test Plan:
- clear mid-T4 of add -> next cycle IDLE, all outputs 0, illegal=bus_err=0.
- run=1, mem_ready tied 1, ir=add R3,R1,R2 -> T0..T5 over 6 cycles with exact strobes per state; T5 has gpr_in=0x0008 and RZLOout=1; back to T0.
- mul R4,R5 -> T5 asserts LOin, T6 asserts HIin with RZHIout; 7 cycles total.
- mem_ready low 3 cycles in T1 -> Read/MDRin held 4 cycles, then T2. With mem_ready never high -> bus_err=1 and halted=1 after WAIT_LIMIT cycles.
- ir opcode 11010 -> halted=1, stays halted with run toggling until clear. Opcode 01100 -> illegal=1, halted=1.
- run dropped during T3 of not -> T4 completes, then IDLE, busy=0. With CTRL_PERF_CNT_EN defined, instr_count increments by 1.
